// File: rtl/guess_game_core.sv
// Number-guessing engine: free-running LFSR secret, guess compare, try budget and countdown timer.
// Latency: one cycle; start, guess and tick effects appear on outputs at the sampling edge.
// Backpressure: none; every guess_valid pulse in PLAY is accepted, one per cycle.
module guess_game_core #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] SEED       = 8'hB7,
    parameter logic [WIDTH-1:0] TAPS       = 8'hB8,
    parameter int               MAX_TRIES  = 7,
    parameter int               TICK_DIV   = 50_000_000,
    parameter int               TIME_LIMIT = 30,
    localparam int              TW         = $clog2(MAX_TRIES + 1),
    localparam int              LW         = $clog2(TIME_LIMIT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             guess_valid,
    input  logic [WIDTH-1:0] guess,
    output logic             big,
    output logic             smal,
    output logic             hit,
    output logic             playing,
    output logic             win,
    output logic             lose,
    output logic [TW-1:0]    tries_left,
    output logic [LW-1:0]    time_left,
    output logic [WIDTH-1:0] secret_out
);

    localparam int               CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;
    localparam logic [CW-1:0]    TICK_TOP = CW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        WIN  = 2'd2,
        LOSE = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] lfsr;
    logic [WIDTH-1:0] secret;
    logic [CW-1:0]    tick_cnt;
    logic             lfsr_phase;

    logic lfsr_fb;
    logic guess_acc;
    logic guess_eq;
    logic guess_gt;
    logic tick_wrap;
    logic timeout;
    logic wrong_last;

    assign lfsr_fb    = ^(lfsr & TAPS);
    assign guess_acc  = (state == PLAY) && guess_valid;
    assign guess_eq   = (guess == secret);
    assign guess_gt   = (guess > secret);
    assign tick_wrap  = (state == PLAY) && (tick_cnt == TICK_TOP);
    assign timeout    = tick_wrap && (time_left == LW'(1));
    assign wrong_last = guess_acc && !guess_eq && (tries_left == TW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lfsr       <= SEED_EFF;
            lfsr_phase <= 1'b0;
            secret     <= '0;
            tick_cnt   <= '0;
            big        <= 1'b0;
            smal       <= 1'b0;
            hit        <= 1'b0;
            playing    <= 1'b0;
            win        <= 1'b0;
            lose       <= 1'b0;
            tries_left <= '0;
            time_left  <= '0;
            secret_out <= '0;
        end else begin
            // The LFSR steps on alternate cycles regardless of game state.
            lfsr_phase <= ~lfsr_phase;
            if (lfsr_phase) begin
                lfsr <= {lfsr[WIDTH-2:0], lfsr_fb};
            end

            case (state)
                IDLE, WIN, LOSE: begin
                    if (start) begin
                        state      <= PLAY;
                        secret     <= lfsr;
                        tries_left <= TW'(MAX_TRIES);
                        time_left  <= LW'(TIME_LIMIT);
                        tick_cnt   <= '0;
                        big        <= 1'b0;
                        smal       <= 1'b0;
                        hit        <= 1'b0;
                        playing    <= 1'b1;
                        win        <= 1'b0;
                        lose       <= 1'b0;
                        secret_out <= '0;
                    end
                end

                PLAY: begin
                    tick_cnt <= tick_wrap ? '0 : tick_cnt + CW'(1);

                    if (guess_acc) begin
                        hit  <= guess_eq;
                        big  <= !guess_eq && guess_gt;
                        smal <= !guess_eq && !guess_gt;
                        if (!guess_eq) begin
                            tries_left <= tries_left - TW'(1);
                        end
                    end

                    // A correct guess freezes the clock on the same cycle it would tick.
                    if (tick_wrap && !(guess_acc && guess_eq)) begin
                        time_left <= time_left - LW'(1);
                    end

                    if (guess_acc && guess_eq) begin
                        state      <= WIN;
                        playing    <= 1'b0;
                        win        <= 1'b1;
                        secret_out <= secret;
                    end else if (wrong_last || timeout) begin
                        state      <= LOSE;
                        playing    <= 1'b0;
                        lose       <= 1'b1;
                        secret_out <= secret;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
